// File: rtl/uart_tx_serialiser.sv
// uart_tx_serialiser
// Byte-to-serial UART transmitter for the SoC debug console. Bytes strobed in
// on tx_send/tx_data are buffered in a small FIFO and sent on uart_tx as 8N1
// frames (start bit, 8 data bits LSB-first, stop bit). Each bit lasts DIV
// clock cycles, where DIV = CLK_MHZ*1e6/BAUD (minimum 1; CLK_MHZ=0 gives one
// clock per bit for simulation).
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   tx_send     in   one-cycle strobe: push tx_data into the FIFO
//   tx_data     in   byte to transmit
//   uart_tx     out  serial line, idle high (registered)
//   tx_full     out  FIFO holds FIFO_DEPTH bytes
//   tx_idle     out  FIFO empty and no frame in progress
//   fifo_count  out  bytes waiting, not counting the byte on the line
//   overflow    out  sticky flag: a tx_send arrived while the FIFO was full
module uart_tx_serialiser #(
    parameter int CLK_MHZ    = 12,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tx_send,
    input  logic [7:0]                    tx_data,
    output logic                          uart_tx,
    output logic                          tx_full,
    output logic                          tx_idle,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int DIV_RAW = (CLK_MHZ * 1000000) / BAUD;
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [DIV_W-1:0] divCnt_q, divCnt_d;
    logic [2:0]       bitCnt_q, bitCnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             line_q, line_d;
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [7:0]       mem_q [FIFO_DEPTH];

    logic canPush;
    logic pop;
    logic divDone;

    // A push is accepted only against the count before the edge, so a pop at
    // the same edge cannot make room for a byte arriving while full.
    assign canPush = tx_send && (count_q != DEPTH_C);
    assign divDone = (divCnt_q == DIV_LAST);

    // Frame sequencing plus FIFO bookkeeping. The line value is computed one
    // cycle ahead so uart_tx comes straight from a flop. Leaving STOP with
    // bytes waiting pops immediately so consecutive frames have no gap.
    always_comb begin
        state_d    = state_q;
        divCnt_d   = divCnt_q;
        bitCnt_d   = bitCnt_q;
        shift_d    = shift_q;
        line_d     = line_q;
        pop        = 1'b0;

        case (state_q)
            S_IDLE: begin
                line_d   = 1'b1;
                divCnt_d = '0;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rdPtr_q];
                    line_d  = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (divDone) begin
                    divCnt_d = '0;
                    bitCnt_d = '0;
                    line_d   = shift_q[0];
                    shift_d  = shift_q >> 1;
                    state_d  = S_DATA;
                end else begin
                    divCnt_d = divCnt_q + DIV_W'(1);
                end
            end
            S_DATA: begin
                if (divDone) begin
                    divCnt_d = '0;
                    if (bitCnt_q == 3'd7) begin
                        line_d  = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        bitCnt_d = bitCnt_q + 3'd1;
                        line_d   = shift_q[0];
                        shift_d  = shift_q >> 1;
                    end
                end else begin
                    divCnt_d = divCnt_q + DIV_W'(1);
                end
            end
            default: begin
                if (divDone) begin
                    divCnt_d = '0;
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rdPtr_q];
                        line_d  = 1'b0;
                        state_d = S_START;
                    end else begin
                        line_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    divCnt_d = divCnt_q + DIV_W'(1);
                end
            end
        endcase

        wrPtr_d = canPush ? wrPtr_q + PTR_W'(1) : wrPtr_q;
        rdPtr_d = pop     ? rdPtr_q + PTR_W'(1) : rdPtr_q;

        case ({canPush, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        overflow_d = overflow_q | (tx_send & ~canPush);
    end

    // State registers; reset abandons any frame and returns the line high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            divCnt_q   <= '0;
            bitCnt_q   <= '0;
            shift_q    <= '0;
            line_q     <= 1'b1;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            divCnt_q   <= divCnt_d;
            bitCnt_q   <= bitCnt_d;
            shift_q    <= shift_d;
            line_q     <= line_d;
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage needs no reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (canPush && !rst) begin
            mem_q[wrPtr_q] <= tx_data;
        end
    end

    assign uart_tx    = line_q;
    assign fifo_count = count_q;
    assign tx_full    = (count_q == DEPTH_C);
    assign tx_idle    = (count_q == '0) && (state_q == S_IDLE);
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_tx_serialiser.sv
// tb_uart_tx_serialiser
// Bench for uart_tx_serialiser. One instance runs at 4 clocks per bit and is
// driven with directed and random byte traffic; a frame-level model predicts
// FIFO occupancy, flags and the line waveform, and a UART receiver process
// decodes uart_tx and checks each frame against a queue of expected bytes.
// A second instance runs in one-clock-per-bit mode for short directed frames.
module tb_uart_tx_serialiser;

    localparam int D     = 4;
    localparam int DEPTH = 4;

    typedef struct {
        logic [7:0] data;
        int         start;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst, txSend;
    logic [7:0] txData;
    logic       uartTx, txFull, txIdle, overflow;
    logic [2:0] fifoCount;

    logic       fRst, fSend;
    logic [7:0] fData;
    logic       fLine, fFull, fIdle, fOvf;
    logic [2:0] fCount;

    int checks   = 0;
    int failures = 0;

    int         cyc = 0;
    logic [7:0] modelQ [$];
    frame_t     expQ [$];
    int         nextPop = 0;
    int         curStart = -1000;
    logic [7:0] curByte = 8'h00;
    bit         expOvf = 1'b0;
    int         epoch = 0;
    int         sizeBefore;
    bit         popNow;
    bit         checking = 1'b0;

    always #5 clk = ~clk;

    uart_tx_serialiser #(.CLK_MHZ(1), .BAUD(250000), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .tx_send(txSend), .tx_data(txData),
        .uart_tx(uartTx), .tx_full(txFull), .tx_idle(txIdle),
        .fifo_count(fifoCount), .overflow(overflow)
    );

    uart_tx_serialiser #(.CLK_MHZ(0), .BAUD(115200), .FIFO_DEPTH(DEPTH)) dutFast (
        .clk(clk), .rst(fRst), .tx_send(fSend), .tx_data(fData),
        .uart_tx(fLine), .tx_full(fFull), .tx_idle(fIdle),
        .fifo_count(fCount), .overflow(fOvf)
    );

    function automatic logic frameBit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        return 1'b1;
    endfunction

    function automatic logic expLine();
        if (cyc >= curStart && cyc < curStart + 10*D)
            return frameBit(curByte, (cyc - curStart) / D);
        return 1'b1;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Drive one cycle of inputs at a falling edge, then move to the next one.
    task automatic applyStimulus(input bit s, input logic [7:0] d, input bit r);
        txSend = s;
        txData = d;
        rst    = r;
        @(negedge clk);
    endtask

    task automatic idleCycles(input int n);
        repeat (n) applyStimulus(1'b0, 8'($urandom), 1'b0);
    endtask

    task automatic waitDrain(input int budget);
        int i = 0;
        while (txIdle !== 1'b1 && i < budget) begin
            applyStimulus(1'b0, 8'($urandom), 1'b0);
            i++;
        end
        checkOutput("drain_tx_idle", txIdle, 1);
    endtask

    // Frame-level model: a byte leaves the queue when the line is free (one
    // frame lasts 10*D cycles) and the queue is non-empty; pushes are judged
    // against the occupancy before the edge.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            modelQ.delete();
            expQ.delete();
            nextPop  = cyc;
            curStart = -1000;
            expOvf   = 1'b0;
            epoch++;
        end else begin
            sizeBefore = modelQ.size();
            popNow     = (sizeBefore > 0) && (cyc >= nextPop);
            if (popNow) begin
                curByte  = modelQ.pop_front();
                curStart = cyc;
                nextPop  = cyc + 10*D;
                expQ.push_back('{data: curByte, start: cyc});
            end
            if (txSend) begin
                if (sizeBefore < DEPTH) modelQ.push_back(txData);
                else expOvf = 1'b1;
            end
        end
    end

    // Every cycle, the main instance's outputs must match the model.
    always @(negedge clk) begin
        if (checking) begin
            checkOutput("uart_tx", uartTx, expLine());
            checkOutput("fifo_count", fifoCount, modelQ.size());
            checkOutput("tx_full", txFull, modelQ.size() == DEPTH);
            checkOutput("tx_idle", txIdle, (modelQ.size() == 0) && (cyc >= nextPop));
            checkOutput("overflow", overflow, expOvf);
        end
    end

    // UART receiver: finds a start bit, samples each bit in its own period,
    // and compares the decoded byte and start time with the scoreboard.
    initial begin : receiver
        int         ep;
        int         st;
        logic [7:0] b;
        logic       stopBit;
        frame_t     f;
        forever begin
            @(negedge clk);
            if (checking && uartTx === 1'b0) begin
                ep = epoch;
                st = cyc;
                for (int k = 1; k <= 8; k++) begin
                    repeat (D) @(negedge clk);
                    b[k-1] = uartTx;
                end
                repeat (D) @(negedge clk);
                stopBit = uartTx;
                if (ep == epoch) begin
                    checkOutput("rx_expected_pending", expQ.size() != 0, 1);
                    if (expQ.size() != 0) begin
                        f = expQ.pop_front();
                        checkOutput("rx_data", b, f.data);
                        checkOutput("rx_start", st, f.start);
                        checkOutput("rx_stop", stopBit, 1);
                    end
                end
            end
        end
    end

    initial begin
        int p;
        rst = 1'b1; txSend = 1'b0; txData = 8'h00;
        fRst = 1'b1; fSend = 1'b0; fData = 8'h00;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_uart_tx", uartTx, 1);
        checkOutput("reset_tx_idle", txIdle, 1);
        checkOutput("reset_fifo_count", fifoCount, 0);
        checkOutput("fast_reset_uart_tx", fLine, 1);
        checkOutput("fast_reset_overflow", fOvf, 0);
        rst = 1'b0;
        fRst = 1'b0;
        checking = 1'b1;

        // One clock per bit: 0x55 gives an alternating line from E1 to E10.
        fSend = 1'b1; fData = 8'h55;
        @(negedge clk);
        fSend = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checkOutput("fast_55_bit", fLine, frameBit(8'h55, k));
        end
        @(negedge clk);
        checkOutput("fast_55_idle", fIdle, 1);

        // 0x00 then 0xFF back-to-back: low 9, high 1, low 1, high 9.
        fSend = 1'b1; fData = 8'h00;
        @(negedge clk);
        fData = 8'hFF;
        @(negedge clk);
        fSend = 1'b0;
        for (int k = 0; k < 20; k++) begin
            checkOutput("fast_00ff_line", fLine,
                        (k < 10) ? frameBit(8'h00, k) : frameBit(8'hFF, k - 10));
            @(negedge clk);
        end
        checkOutput("fast_00ff_idle", fIdle, 1);

        // Single frame of 0xA3 at four clocks per bit.
        applyStimulus(1'b1, 8'hA3, 1'b0);
        waitDrain(100);

        // Six pushes in a row: one goes on the line, four fill, one drops.
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'($urandom), 1'b0);
        checkOutput("burst_tx_full", txFull, 1);
        checkOutput("burst_overflow", overflow, 1);
        waitDrain(400);
        applyStimulus(1'b0, 8'h00, 1'b1);

        // Push while full on the very edge a stop bit ends and a byte pops.
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'($urandom), 1'b0);
        while (cyc < nextPop - 1) applyStimulus(1'b0, 8'($urandom), 1'b0);
        applyStimulus(1'b1, 8'h5A, 1'b0);
        checkOutput("popedge_fifo_count", fifoCount, 3);
        checkOutput("popedge_overflow", overflow, 1);
        waitDrain(400);
        applyStimulus(1'b0, 8'h00, 1'b1);

        // Reset during data bit 3 with two bytes still queued.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'($urandom), 1'b0);
        p = curStart;
        while (cyc < p + 4*D) applyStimulus(1'b0, 8'($urandom), 1'b0);
        applyStimulus(1'b1, 8'hEE, 1'b1);
        checkOutput("midreset_uart_tx", uartTx, 1);
        checkOutput("midreset_fifo_count", fifoCount, 0);
        checkOutput("midreset_tx_idle", txIdle, 1);
        idleCycles(60);

        // Random traffic: sparse, then dense enough to overflow.
        repeat (600) applyStimulus($urandom_range(0, 49) == 0, 8'($urandom), 1'b0);
        repeat (600) applyStimulus($urandom_range(0, 5) == 0, 8'($urandom), 1'b0);
        waitDrain(400);
        idleCycles(5);
        checkOutput("scoreboard_empty", expQ.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
